deco_2_a_4: RTL and testbench
=============================

# deco_2_a_4

Registered 2-to-4 one-hot decoder with enable, used in the DPWM datapath to turn a 2-bit segment/phase index into four individual select lines. The default build has a 2-bit input and a 4-bit one-hot output. The output is registered on the system clock so downstream PWM comparators see glitch-free selects. Width and output polarity are parameterizable for reuse by other selector stages.

## Interface
- `IN_W`, default 2: input index width; output width is 2**IN_W (default 4).
- `ACTIVE_LOW`, default 0: 0 means the selected bit is 1 and the rest are 0. 1 means the whole output vector is inverted, including the disabled and reset values.
- `CLK` input 1: system clock; all state updates on the rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `IN` input IN_W: binary index to decode.
- `EN` input 1: decode enable; active-high.
- `OUT` output 2**IN_W: registered one-hot decode of `IN`.

## Operation
- On each rising `CLK` edge with `RST`=0 and `EN`=1: `OUT` is set to 1 << `IN`. Exactly one bit is high.
  - Default width: `IN`=0 → 0001, 1 → 0010, 2 → 0100, 3 → 1000.
- With `EN`=0: `OUT` is set to all zeros. No bit is selected.
- `ACTIVE_LOW`=1: the final registered value is bitwise inverted (disabled gives 1111, `IN`=2 gives 1011).
- All values of `IN` are legal; there is no out-of-range case because the output covers 2**IN_W codes.
- X/Z on `IN` while `EN`=1 is not supported. Simulation assertion: `IN` is known whenever `EN`=1.

## Timing
- Latency is 1 clock: `IN`/`EN` sampled at edge k appear on `OUT` after edge k. The output holds until the next edge.
- Reset:
  - `RST`=1 at an edge forces `OUT` to the disabled value (0000, or 1111 when `ACTIVE_LOW`=1), regardless of `EN`/`IN`.
  - `RST` has priority over `EN`.
  - Reset asserted mid-operation clears `OUT` at the next edge.
  - Decoding resumes on the first edge after `RST` falls, using the `IN`/`EN` present at that edge.
- `EN` and `IN` changing together at the same edge: the new `IN` is decoded if the new `EN`=1.
- `OUT` never shows two bits set at once. Bits switch simultaneously at the clock edge, with no combinational path from `IN`/`EN` to `OUT`.
- No internal state other than the `OUT` register; no handshake.

## Structure
- Shared package `dpwm_pkg` holds:
  - `DECO_IN_W` = 2 and derived `DECO_OUT_W` = 4 (the DPWM segment-select width);
  - a `deco_sel_t` typedef for the 4-bit select vector, used by consumers.
- One natural sub-module: `deco_onehot_core`, the purely combinational binary-to-one-hot function with enable. `deco_2_a_4` wraps it with the synchronous-reset output register and polarity inversion.
- Parameter checks at elaboration: `IN_W` must be ≥1 and ≤5.

## Test plan
- Reset: `RST`=1 for 2 cycles with `EN`=1, `IN`=3 → `OUT`=0000 throughout. Release `RST` → `OUT`=1000 one cycle later.
- Sweep: `EN`=1; `IN`=0,1,2,3 on consecutive cycles → `OUT`=0001, 0010, 0100, 1000, each one cycle after the stimulus.
- Enable off: `IN`=3, `EN`=0 → `OUT`=0000 next cycle. `EN`=1 again → `OUT`=1000 next cycle.
- Mid-operation reset: `OUT`=0100 (`IN`=2), pulse `RST` for 1 cycle → `OUT`=0000 for that cycle, then 0100.
- Polarity: `ACTIVE_LOW`=1, `IN`=1, `EN`=1 → `OUT`=1101. `EN`=0 → 1111. Reset → 1111.
- Random: 1000 cycles of random `IN`/`EN`/`RST` checked against a 1-cycle-delayed reference model; `$onehot0(OUT)` (default polarity) holds every cycle.

Source files
------------

// File: rtl/dpwm_pkg.sv
// Shared DPWM datapath types and widths.
// Holds the segment-select decoder sizing and the select vector typedef.
package dpwm_pkg;

    // Segment/phase index width and the derived one-hot select width.
    localparam int DECO_IN_W  = 2;
    localparam int DECO_OUT_W = 1 << DECO_IN_W;

    // One-hot segment select vector as seen by the PWM comparators.
    typedef logic [DECO_OUT_W-1:0] deco_sel_t;

    // Decoder polarity options.
    typedef enum logic {
        DECO_ACT_HIGH = 1'b0,
        DECO_ACT_LOW  = 1'b1
    } deco_pol_e;

endpackage

// File: rtl/deco_onehot_core.sv
// Combinational binary-to-one-hot decode with enable.
// Ports: in_i (index), en_i (enable), sel_o (one-hot, all zero when disabled).
module deco_onehot_core #(
    parameter int IN_W  = 2,
    parameter int OUT_W = 1 << IN_W
) (
    input  logic [IN_W-1:0]  in_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] sel_o
);

    always_comb begin
        sel_o = '0;
        for (int i = 0; i < OUT_W; i++) begin
            sel_o[i] = en_i && (in_i == IN_W'(i));
        end
    end

endmodule

// File: rtl/deco_2_a_4.sv
// Registered one-hot decoder with enable and selectable output polarity.
// Ports: CLK, RST (sync, active-high), IN (index), EN (enable), OUT (registered select).
module deco_2_a_4
    import dpwm_pkg::*;
#(
    parameter int IN_W       = DECO_IN_W,
    parameter bit ACTIVE_LOW = DECO_ACT_HIGH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [IN_W-1:0]      IN,
    input  logic                 EN,
    output logic [(1<<IN_W)-1:0] OUT
);

    localparam int OUT_W = 1 << IN_W;

    // Inversion mask doubles as the disabled/reset value.
    localparam logic [OUT_W-1:0] POL_MASK = {OUT_W{ACTIVE_LOW}};

    generate
        if ((IN_W < 1) || (IN_W > 5)) begin : g_bad_w
            $error("deco_2_a_4: IN_W must be in 1..5");
        end
    endgenerate

    logic [OUT_W-1:0] sel;
    logic [OUT_W-1:0] out_d;
    logic [OUT_W-1:0] out_q;

    deco_onehot_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_i  (IN),
        .en_i  (EN),
        .sel_o (sel)
    );

    assign out_d = sel ^ POL_MASK;

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q <= POL_MASK;
        end else begin
            out_q <= out_d;
        end
    end

    assign OUT = out_q;

`ifndef SYNTHESIS
    in_known_a: assert property (@(posedge CLK) EN |-> !$isunknown(IN));
`endif

endmodule

// File: tb/tb_deco_2_a_4.sv
// Bench for deco_2_a_4: both polarities driven in parallel.
// Reference model plus directed literal checks and a random phase.
module tb_deco_2_a_4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] din;
    logic [3:0] out_hi;
    logic [3:0] out_lo;

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_q;
    bit         mvalid = 0;

    deco_2_a_4 #(.IN_W(2), .ACTIVE_LOW(1'b0)) u_hi (
        .CLK (clk),
        .RST (rst),
        .IN  (din),
        .EN  (en),
        .OUT (out_hi)
    );

    deco_2_a_4 #(.IN_W(2), .ACTIVE_LOW(1'b1)) u_lo (
        .CLK (clk),
        .RST (rst),
        .IN  (din),
        .EN  (en),
        .OUT (out_lo)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference: selected bit is 2**IN, nothing when disabled or in reset.
    always @(posedge clk) begin
        if (rst || !en) exp_q <= 4'd0;
        else            exp_q <= 4'(1 << din);
        mvalid <= 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            tests++;
            if (out_hi !== exp_q) begin
                fails++;
                $display("FAIL model_hi: got %b want %b", out_hi, exp_q);
            end
            tests++;
            if (out_lo !== ~exp_q) begin
                fails++;
                $display("FAIL model_lo: got %b want %b", out_lo, ~exp_q);
            end
            tests++;
            if (!$onehot0(out_hi)) begin
                fails++;
                $display("FAIL onehot0: got %b want at most one bit", out_hi);
            end
        end
    end

    task automatic cyc(input logic r, input logic e, input logic [1:0] i);
        rst = r;
        en  = e;
        din = i;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] act,
                       input logic [3:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    initial begin
        rst = 1;
        en  = 0;
        din = 0;
        @(negedge clk);

        cyc(1, 1, 3); chk("rst0", out_hi, 4'b0000);
        cyc(1, 1, 3); chk("rst1", out_hi, 4'b0000);
        cyc(0, 1, 3); chk("rel", out_hi, 4'b1000);

        cyc(0, 1, 0); chk("sw0", out_hi, 4'b0001);
        cyc(0, 1, 1); chk("sw1", out_hi, 4'b0010);
        cyc(0, 1, 2); chk("sw2", out_hi, 4'b0100);
        cyc(0, 1, 3); chk("sw3", out_hi, 4'b1000);

        cyc(0, 0, 3); chk("en_off", out_hi, 4'b0000);
        cyc(0, 1, 3); chk("en_on", out_hi, 4'b1000);

        cyc(0, 1, 2); chk("mid_pre", out_hi, 4'b0100);
        cyc(1, 1, 2); chk("mid_rst", out_hi, 4'b0000);
        cyc(0, 1, 2); chk("mid_post", out_hi, 4'b0100);

        cyc(0, 1, 1); chk("lo_sel", out_lo, 4'b1101);
        cyc(0, 0, 1); chk("lo_dis", out_lo, 4'b1111);
        cyc(1, 1, 2); chk("lo_rst", out_lo, 4'b1111);
        cyc(0, 1, 2); chk("lo_in2", out_lo, 4'b1011);

        for (int k = 0; k < 1000; k++) begin
            cyc(($urandom_range(0, 15) == 0), 1'($urandom),
                2'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
